// File: rtl/baud_tick_generator_if.sv
// Control and strobe bundle between the baud tick generator and its UART users.
// The master drives the controls; the generator (slave) drives the strobes.
interface baud_tick_generator_if #(
   parameter int ACC_WIDTH  = 24,
   parameter int OVERSAMPLE = 16
);
   localparam int PW = $clog2(OVERSAMPLE);

   logic                 enable;
   logic                 load;
   logic [ACC_WIDTH-1:0] inc_in;
   logic                 sync;
   logic                 os_tick;
   logic                 baud_tick;
   logic [PW-1:0]        os_phase;
   logic                 bclk;

   modport master (
      output enable, load, inc_in, sync,
      input  os_tick, baud_tick, os_phase, bclk
   );

   modport slave (
      input  enable, load, inc_in, sync,
      output os_tick, baud_tick, os_phase, bclk
   );
endinterface

// File: rtl/baud_tick_generator.sv
// Fractional phase-accumulator baud generator: oversample strobe, baud strobe
// and a square-wave BCLK, with runtime reload and start-bit resynchronisation.
module baud_tick_generator #(
   parameter longint unsigned CLOCK_RATE   = 25000000,
   parameter longint unsigned DEFAULT_BAUD = 57600,
   parameter int              OVERSAMPLE   = 16,
   parameter int              ACC_WIDTH    = 24,
   parameter longint unsigned DEFAULT_INC  =
      (DEFAULT_BAUD * longint'(OVERSAMPLE) * (64'd1 << ACC_WIDTH)
       + CLOCK_RATE / 2) / CLOCK_RATE
) (
   input logic                  clk,
   input logic                  reset,
   baud_tick_generator_if.slave bus
);
   localparam int PW = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] OS_LAST = PW'(OVERSAMPLE - 1);
   localparam logic [PW-1:0] OS_HALF = PW'(OVERSAMPLE / 2);
   localparam logic [ACC_WIDTH-1:0] INC_RST = ACC_WIDTH'(DEFAULT_INC);
   localparam logic [ACC_WIDTH-1:0] ACC_MID = ACC_WIDTH'(64'd1 << (ACC_WIDTH - 1));

   if (OVERSAMPLE < 2 || OVERSAMPLE > 256) begin : g_bad_os
      $error("OVERSAMPLE out of range 2..256");
   end
   if (ACC_WIDTH < 8 || ACC_WIDTH > 32) begin : g_bad_acc
      $error("ACC_WIDTH out of range 8..32");
   end
   if (DEFAULT_INC == 0 || DEFAULT_INC >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
      $error("DEFAULT_INC must be in 1..2^ACC_WIDTH-1");
   end

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] inc_reg;
   logic [PW-1:0]        os_cnt;
   logic                 os_tick;
   logic                 baud_tick;
   logic                 bclk;

   logic                 carry;
   logic [ACC_WIDTH-1:0] sum;
   logic                 os_wrap;
   logic [PW-1:0]        os_nxt;

   always_comb begin
      {carry, sum} = {1'b0, acc} + {1'b0, inc_reg};
      os_wrap      = (os_cnt == OS_LAST);
      os_nxt       = os_wrap ? '0 : os_cnt + 1'b1;
   end

   // SYNC outranks the step; LOAD acts alongside either, and the add in a
   // LOAD cycle still uses the previous increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         inc_reg   <= INC_RST;
         os_cnt    <= '0;
         os_tick   <= 1'b0;
         baud_tick <= 1'b0;
         bclk      <= 1'b0;
      end else begin
         if (bus.load) begin
            inc_reg <= bus.inc_in;
         end
         if (bus.sync) begin
            acc       <= ACC_MID;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
            bclk      <= 1'b1;
         end else if (bus.enable) begin
            acc       <= sum;
            os_tick   <= carry;
            baud_tick <= carry && os_wrap;
            if (carry) begin
               os_cnt <= os_nxt;
               bclk   <= (os_nxt < OS_HALF);
            end
         end else begin
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
         end
      end
   end

   assign bus.os_tick   = os_tick;
   assign bus.baud_tick = baud_tick;
   assign bus.os_phase  = os_cnt;
   assign bus.bclk      = bclk;
endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench: default-config generator for reset/fractional rate, and an
// 8-bit, 4x-oversample generator for exact-rate, freeze, resync and reload.
module tb_baud_tick_generator;
   localparam int MON_CYC   = 50000;
   localparam int EXP_TICKS = int'((64'(MON_CYC) * 64'd618475) >> 24);

   logic clk;
   logic rst_big;
   logic rst_sml;

   int checks = 0;
   int fails  = 0;

   int mon_on    = 0;
   int mon_cyc   = 0;
   int mon_ticks = 0;
   int mon_bad   = 0;
   int mon_last  = 0;

   baud_tick_generator_if bus_big ();
   baud_tick_generator_if #(.ACC_WIDTH(8), .OVERSAMPLE(4)) bus_sml ();

   baud_tick_generator dut_big (
      .clk   (clk),
      .reset (rst_big),
      .bus   (bus_big)
   );

   baud_tick_generator #(
      .CLOCK_RATE   (1024),
      .DEFAULT_BAUD (16),
      .OVERSAMPLE   (4),
      .ACC_WIDTH    (8)
   ) dut_sml (
      .clk   (clk),
      .reset (rst_sml),
      .bus   (bus_sml)
   );

   always #5 clk = ~clk;

   // Tick counting and gap measurement on the default-config generator.
   always @(negedge clk) begin
      if (mon_on != 0 && mon_cyc < MON_CYC) begin
         mon_cyc++;
         if (bus_big.os_tick) begin
            mon_ticks++;
            if (mon_last > 0 && (mon_cyc - mon_last) != 27 && (mon_cyc - mon_last) != 28)
               mon_bad++;
            mon_last = mon_cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] pk(input bit t, input bit b, input bit c, input int p);
      logic [1:0] ph;
      ph = 2'(p);
      return {t, b, c, ph};
   endfunction

   task automatic chk_s(input string tag, input logic [4:0] exp);
      check(tag, {27'd0, bus_sml.os_tick, bus_sml.baud_tick, bus_sml.bclk,
                  bus_sml.os_phase}, {27'd0, exp});
   endtask

   initial begin
      int cnt;
      int guard;
      clk = 0;
      rst_big = 1;
      rst_sml = 1;
      bus_big.enable = 1;
      bus_big.load   = 1;
      bus_big.inc_in = 24'h40;
      bus_big.sync   = 0;
      bus_sml.enable = 1;
      bus_sml.load   = 1;
      bus_sml.inc_in = 8'd200;
      bus_sml.sync   = 0;
      repeat (3) step();
      check("rst_big", {bus_big.os_tick, bus_big.baud_tick, bus_big.bclk, bus_big.os_phase}, 0);
      chk_s("rst_sml", pk(0, 0, 0, 0));

      rst_big = 0;
      rst_sml = 0;
      bus_big.load = 0;
      bus_sml.load = 0;
      bus_sml.enable = 0;
      mon_on = 1;

      // 27*618475 < 2^24 < 28*618475: first carry on the 28th add.
      for (int k = 1; k <= 27; k++) begin
         step();
         check("first_tick_wait", bus_big.os_tick, 0);
      end
      step();
      check("first_tick", {bus_big.os_tick, bus_big.bclk, bus_big.os_phase}, {1'b1, 1'b1, 4'd1});
      chk_s("sml_idle", pk(0, 0, 0, 0));

      bus_sml.load = 1;
      bus_sml.inc_in = 8'd64;
      step();
      bus_sml.load = 0;
      bus_sml.enable = 1;
      for (int k = 1; k <= 38; k++) begin
         step();
         cnt = (k / 4) % 4;
         chk_s("exact_rate", pk(k % 4 == 0, k % 16 == 0, k >= 4 && cnt < 2, cnt));
      end

      bus_sml.enable = 0;
      repeat (10) begin
         step();
         chk_s("freeze", pk(0, 0, 1, 1));
      end
      bus_sml.enable = 1;
      step();
      chk_s("resume_1", pk(0, 0, 1, 1));
      step();
      chk_s("resume_2", pk(1, 0, 0, 2));

      step();
      chk_s("pre_sync", pk(0, 0, 0, 2));
      bus_sml.sync = 1;
      step();
      bus_sml.sync = 0;
      chk_s("sync", pk(0, 0, 1, 0));
      for (int j = 1; j <= 14; j++) begin
         step();
         cnt = ((j + 2) / 4) % 4;
         chk_s("after_sync", pk(j % 4 == 2, j == 14, cnt < 2, cnt));
      end

      step();
      step();
      chk_s("pre_reload", pk(0, 0, 1, 0));
      bus_sml.load = 1;
      bus_sml.inc_in = 8'd128;
      step();
      bus_sml.load = 0;
      chk_s("reload_edge", pk(0, 0, 1, 0));
      for (int j = 1; j <= 6; j++) begin
         step();
         cnt = (j + 1) / 2;
         chk_s("reload_rate", pk(j % 2 == 1, 0, cnt < 2, cnt));
      end

      bus_sml.load = 1;
      bus_sml.inc_in = 8'd0;
      step();
      bus_sml.load = 0;
      chk_s("load_zero_edge", pk(1, 1, 1, 0));
      repeat (100) begin
         step();
         chk_s("inc_zero_hold", pk(0, 0, 1, 0));
      end

      bus_sml.load = 1;
      bus_sml.inc_in = 8'd64;
      bus_sml.sync = 1;
      step();
      bus_sml.load = 0;
      bus_sml.sync = 0;
      chk_s("load_sync", pk(0, 0, 1, 0));
      step();
      chk_s("load_sync_1", pk(0, 0, 1, 0));
      step();
      chk_s("load_sync_2", pk(1, 0, 1, 1));

      rst_sml = 1;
      bus_sml.load = 1;
      bus_sml.inc_in = 8'h80;
      step();
      chk_s("mid_reset", pk(0, 0, 0, 0));
      rst_sml = 0;
      bus_sml.load = 0;
      for (int k = 1; k <= 15; k++) begin
         step();
         chk_s("reset_inc_wait", pk(0, 0, 0, 0));
      end
      step();
      chk_s("reset_inc_tick", pk(1, 0, 1, 1));

      guard = 0;
      while (mon_cyc < MON_CYC && guard < 60000) begin
         step();
         guard++;
      end
      check("mon_done", mon_cyc, MON_CYC);
      check("frac_count", mon_ticks, EXP_TICKS);
      check("frac_gaps", mon_bad, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
